// File: rtl/evm_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// evm_pkg : shared types and helpers for the voting-machine front end
// rev 1.0
// ------------------------------------------------------------------
package evm_pkg;

  localparam int NUM_BUTTONS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    RELEASE = 2'd2
  } cond_state_t;

  function automatic logic [NUM_BUTTONS-1:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_cell.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_cell : SYNC_STAGES-deep flop chain, async reset to 0
// rev 1.0
// ------------------------------------------------------------------
module sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ------------------------------------------------------------------
// button_conditioner : sync + debounce 4 buttons, one pulse per press
// rev 1.0
// ------------------------------------------------------------------
module button_conditioner
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_in,
  input  logic                   mode_in,
  output logic [NUM_BUTTONS-1:0] vote_pulse,
  output logic                   mode_sync,
  output logic                   press_err,
  output logic                   busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // cnt includes the sample being evaluated, so the D-th sample is seen at cnt == D-1
  localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] w_bsync;
  logic                   w_mode_sync;
  logic                   w_multi;
  logic [1:0]             w_enc;

  cond_state_t            r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [1:0]             r_sel, w_sel_nxt;
  logic                   r_mode_lat, w_mode_lat_nxt;
  logic [NUM_BUTTONS-1:0] r_vote_pulse, w_vote_pulse_nxt;
  logic                   r_press_err, w_press_err_nxt;
  logic                   r_busy;

  generate
    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn_sync
      sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (button_in[gi]),
        .o_q   (w_bsync[gi])
      );
    end
  endgenerate

  sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (mode_in),
    .o_q   (w_mode_sync)
  );

  assign w_multi = (w_bsync & (w_bsync - 1'b1)) != '0;

  always_comb begin
    w_enc = 2'd0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (w_bsync[i]) w_enc = 2'(i);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_sel_nxt        = r_sel;
    w_mode_lat_nxt   = r_mode_lat;
    w_vote_pulse_nxt = '0;
    w_press_err_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_bsync != '0) begin
          if (w_multi) begin
            w_press_err_nxt = 1'b1;
            w_cnt_nxt       = '0;
            w_state_nxt     = RELEASE;
          end else begin
            w_sel_nxt      = w_enc;
            w_mode_lat_nxt = w_mode_sync;
            w_cnt_nxt      = CW'(1);
            w_state_nxt    = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (w_bsync == '0) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if ((w_bsync != onehot4(r_sel)) || (w_mode_sync != r_mode_lat)) begin
          w_press_err_nxt = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = RELEASE;
        end else if (r_cnt >= c_cnt_last) begin
          w_vote_pulse_nxt = onehot4(r_sel);
          w_cnt_nxt        = '0;
          w_state_nxt      = RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (w_bsync != '0) begin
          w_cnt_nxt = '0;
        end else if (r_cnt >= c_cnt_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_mode_lat   <= 1'b0;
      r_vote_pulse <= '0;
      r_press_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_mode_lat   <= w_mode_lat_nxt;
      r_vote_pulse <= w_vote_pulse_nxt;
      r_press_err  <= w_press_err_nxt;
      r_busy       <= (w_state_nxt != IDLE);
    end
  end

  assign vote_pulse = r_vote_pulse;
  assign press_err  = r_press_err;
  assign busy       = r_busy;
  assign mode_sync  = w_mode_sync;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_button_conditioner : directed self-checking bench
// rev 1.0
// ------------------------------------------------------------------
module tb_button_conditioner;

  logic       clk;
  logic       reset;
  logic [3:0] button_in;
  logic       mode_in;
  logic [3:0] vote_pulse;
  logic       mode_sync;
  logic       press_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  // per-scenario observation, tick 1 = first edge sampling the new input
  int         tick;
  int         pulse_cnt;
  int         pulse_tick;
  logic [3:0] pulse_val;
  int         err_cnt;
  int         err_tick;
  int         viol;

  button_conditioner #(
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button_in  (button_in),
    .mode_in    (mode_in),
    .vote_pulse (vote_pulse),
    .mode_sync  (mode_sync),
    .press_err  (press_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    tick       = 0;
    pulse_cnt  = 0;
    pulse_tick = -1;
    pulse_val  = 4'b0000;
    err_cnt    = 0;
    err_tick   = -1;
    viol       = 0;
  endtask

  task automatic run(input logic [3:0] btn, input logic mode, input int n);
    for (int i = 0; i < n; i++) begin
      button_in = btn;
      mode_in   = mode;
      @(posedge clk);
      #1;
      tick++;
      if (vote_pulse != 4'b0000) begin
        pulse_cnt++;
        pulse_val  = vote_pulse;
        pulse_tick = tick;
      end
      if (press_err) begin
        err_cnt++;
        err_tick = tick;
      end
      if ((vote_pulse != 4'b0000) && press_err) viol++;
      if ((vote_pulse & (vote_pulse - 4'd1)) != 4'b0000) viol++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    button_in = 4'b0000;
    mode_in   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_vote", 32'(vote_pulse), 32'h0);
    check_eq("rst_err",  32'(press_err),  32'h0);
    check_eq("rst_busy", 32'(busy),       32'h0);
    check_eq("rst_mode", 32'(mode_sync),  32'h0);
    reset = 1'b0;

    // single clean press of button1
    clear_stats();
    run(4'b0001, 1'b0, 10);
    run(4'b0000, 1'b0, 20);
    check_eq("t1_pulse_cnt",  32'(pulse_cnt),  32'd1);
    check_eq("t1_pulse_val",  32'(pulse_val),  32'h1);
    check_eq("t1_pulse_tick", 32'(pulse_tick), 32'd10);
    check_eq("t1_err_cnt",    32'(err_cnt),    32'd0);
    check_eq("t1_busy_end",   32'(busy),       32'h0);

    // short press of button2 never qualifies
    clear_stats();
    run(4'b0010, 1'b0, 5);
    check_eq("t2_busy_mid",  32'(busy),      32'h1);
    run(4'b0000, 1'b0, 15);
    check_eq("t2_pulse_cnt", 32'(pulse_cnt), 32'd0);
    check_eq("t2_err_cnt",   32'(err_cnt),   32'd0);
    check_eq("t2_busy_end",  32'(busy),      32'h0);

    // button1 + button3 together: error, then release window of 8 lows
    clear_stats();
    run(4'b0101, 1'b0, 10);
    run(4'b0000, 1'b0, 9);
    check_eq("t3_err_cnt",   32'(err_cnt),   32'd1);
    check_eq("t3_err_tick",  32'(err_tick),  32'd3);
    check_eq("t3_busy_7low", 32'(busy),      32'h1);
    run(4'b0000, 1'b0, 1);
    check_eq("t3_busy_8low", 32'(busy),      32'h0);
    check_eq("t3_pulse_cnt", 32'(pulse_cnt), 32'd0);

    // bouncing button4, then a solid hold
    clear_stats();
    for (int r = 0; r < 5; r++) begin
      run(4'b1000, 1'b0, 3);
      run(4'b0000, 1'b0, 3);
    end
    run(4'b1000, 1'b0, 10);
    run(4'b0000, 1'b0, 20);
    check_eq("t4_pulse_cnt",  32'(pulse_cnt),  32'd1);
    check_eq("t4_pulse_val",  32'(pulse_val),  32'h8);
    check_eq("t4_pulse_tick", 32'(pulse_tick), 32'd40);
    check_eq("t4_err_cnt",    32'(err_cnt),    32'd0);

    // mode flips mid-qualify on button3
    clear_stats();
    run(4'b0100, 1'b0, 5);
    run(4'b0100, 1'b1, 10);
    run(4'b0000, 1'b1, 20);
    check_eq("t5_err_cnt",   32'(err_cnt),   32'd1);
    check_eq("t5_err_tick",  32'(err_tick),  32'd8);
    check_eq("t5_pulse_cnt", 32'(pulse_cnt), 32'd0);
    check_eq("t5_mode_sync", 32'(mode_sync), 32'h1);
    check_eq("t5_busy_end",  32'(busy),      32'h0);
    clear_stats();
    run(4'b0100, 1'b1, 10);
    run(4'b0000, 1'b1, 20);
    check_eq("t5b_pulse_cnt",  32'(pulse_cnt),  32'd1);
    check_eq("t5b_pulse_val",  32'(pulse_val),  32'h4);
    check_eq("t5b_pulse_tick", 32'(pulse_tick), 32'd10);
    check_eq("t5b_err_cnt",    32'(err_cnt),    32'd0);

    // reset during a button1 press, released with the button still held
    clear_stats();
    run(4'b0001, 1'b1, 6);
    check_eq("t6_busy_pre", 32'(busy), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("t6_rst_vote", 32'(vote_pulse), 32'h0);
    check_eq("t6_rst_err",  32'(press_err),  32'h0);
    check_eq("t6_rst_busy", 32'(busy),       32'h0);
    check_eq("t6_rst_mode", 32'(mode_sync),  32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_hold_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    check_eq("t6_pre_pulse", 32'(pulse_cnt), 32'd0);
    clear_stats();
    // pulse lands 9 edges after the first sampling edge following deassertion
    run(4'b0001, 1'b1, 12);
    run(4'b0000, 1'b1, 20);
    check_eq("t6_pulse_cnt",  32'(pulse_cnt),  32'd1);
    check_eq("t6_pulse_val",  32'(pulse_val),  32'h1);
    check_eq("t6_pulse_tick", 32'(pulse_tick), 32'd10);
    check_eq("t6_err_cnt",    32'(err_cnt),    32'd0);
    check_eq("t6_invariants", 32'(viol),       32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
